// File: rtl/mem_arb_pkg.sv
// ----------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the memory-port arbiter: FSM state encodings,
// requester (owner) identifiers and a helper that sizes the grant-timeout
// counter from the TIMEOUT parameter.
// ----------------------------------------------------------------------------
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  // Counter only needs to reach TIMEOUT-1; keep at least one bit so the
  // register still exists when the timeout is disabled or trivially small.
  function automatic int cnt_width(input int timeout);
    if (timeout <= 2) begin
      return 1;
    end
    return $clog2(timeout);
  endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// ----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin picker for the fetch and data requesters.
//   req_if  : fetch path is requesting
//   req_d   : data path is requesting
//   rr_last : owner that won the previous arbitration
//   en      : arbitration allowed this cycle (parent FSM is idle)
//   gnt     : one-hot grant, bit 0 = fetch, bit 1 = data
// ----------------------------------------------------------------------------
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       req_if,
  input  logic       req_d,
  input  owner_t     rr_last,
  input  logic       en,
  output logic [1:0] gnt
);

  // A lone requester always wins; on a tie the side that did not win last
  // time gets the port, so neither path can starve the other.
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req_if && req_d) begin
        if (rr_last == OWN_D) begin
          gnt = 2'b01;
        end else begin
          gnt = 2'b10;
        end
      end else if (req_if) begin
        gnt = 2'b01;
      end else if (req_d) begin
        gnt = 2'b10;
      end
    end
  end

endmodule

// File: rtl/mem_arb.sv
// ----------------------------------------------------------------------------
// mem_arb
// Shares one external memory port between the instruction-fetch path and the
// load/store data path. One bus transaction is outstanding at a time; it runs
// through an address phase (bus_req until bus_gnt) and a response phase
// (until bus_rvalid). The response is registered and steered back to the
// requester that owns the transaction.
//
// Ports:
//   clk, rstn                      clock, asynchronous active-low reset
//   if_req/if_addr                 fetch request (held until if_gnt)
//   if_gnt/if_rvalid/if_rdata/if_err  fetch grant pulse and response
//   d_req/d_wr/d_bytes/d_addr/d_wdata data request (held until d_gnt)
//   d_gnt/d_rvalid/d_rdata/d_err   data grant pulse and response
//   bus_req/bus_wr/bus_bytes/bus_addr/bus_wdata  bus address phase
//   bus_gnt/bus_rvalid/bus_rdata/bus_err         bus handshake and response
//
// Parameters:
//   XLEN     data/address width (32 or 64)
//   TIMEOUT  address-phase cycles allowed before aborting with error; 0 = off
// ----------------------------------------------------------------------------
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rstn,

  input  logic              if_req,
  input  logic [XLEN-1:0]   if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  output logic              if_err,

  input  logic              d_req,
  input  logic              d_wr,
  input  logic [XLEN/8-1:0] d_bytes,
  input  logic [XLEN-1:0]   d_addr,
  input  logic [XLEN-1:0]   d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [XLEN-1:0]   d_rdata,
  output logic              d_err,

  output logic              bus_req,
  output logic              bus_wr,
  output logic [XLEN/8-1:0] bus_bytes,
  output logic [XLEN-1:0]   bus_addr,
  output logic [XLEN-1:0]   bus_wdata,
  input  logic              bus_gnt,
  input  logic              bus_rvalid,
  input  logic [XLEN-1:0]   bus_rdata,
  input  logic              bus_err
);

  localparam int BW = XLEN / 8;
  localparam int CW = cnt_width(TIMEOUT);

  typedef logic [CW-1:0] cnt_t;

  // Last address-phase cycle before giving up. Meaningless when TIMEOUT is 0,
  // where the comparison is never enabled.
  localparam cnt_t CNT_LAST = cnt_t'(TIMEOUT - 1);

  state_t            state;
  state_t            state_nxt;
  cnt_t              cnt;
  cnt_t              cnt_nxt;
  owner_t            rr_last;
  owner_t            owner_q;
  logic              wr_q;
  logic [BW-1:0]     bytes_q;
  logic [XLEN-1:0]   addr_q;
  logic [XLEN-1:0]   wdata_q;

  logic              arb_en;
  logic [1:0]        gnt;
  logic              misaligned;
  logic              fetch_fault;
  logic              capture;
  logic              abort;
  logic              bus_done;
  logic [BW-1:0]     fetch_bytes;
  logic [31:0]       fetch_word;

  assign arb_en = (state == ST_IDLE);

  rr_arb2 u_rr_arb2 (
    .req_if  (if_req),
    .req_d   (d_req),
    .rr_last (rr_last),
    .en      (arb_en),
    .gnt     (gnt)
  );

  // An instruction fetch that is not word aligned is still granted so the
  // core can move on, but it never reaches the bus; it just returns an error.
  assign misaligned  = (if_addr[1:0] != 2'b00);
  assign fetch_fault = gnt[0] && misaligned;
  assign capture     = (gnt[0] && !misaligned) || gnt[1];

  // Fetches are 32-bit: on a 64-bit bus pick the lane from address bit 2,
  // both for the byte enables going out and the word coming back.
  if (XLEN == 64) begin : g_lane64
    assign fetch_bytes = if_addr[2] ? BW'(8'hF0) : BW'(8'h0F);
    assign fetch_word  = addr_q[2] ? bus_rdata[63:32] : bus_rdata[31:0];
  end else begin : g_lane32
    assign fetch_bytes = '1;
    assign fetch_word  = bus_rdata[31:0];
  end

  // State and timeout counter registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic plus the combinational grant/bus-request outputs.
  // The counter counts address-phase cycles without bus_gnt; reaching the
  // last allowed cycle abandons the transaction with an error response.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    abort     = 1'b0;
    bus_done  = 1'b0;
    bus_req   = 1'b0;
    if_gnt    = gnt[0];
    d_gnt     = gnt[1];
    case (state)
      ST_IDLE: begin
        if (capture) begin
          state_nxt = ST_ADDR;
          cnt_nxt   = '0;
        end
      end
      ST_ADDR: begin
        bus_req = 1'b1;
        if (bus_gnt) begin
          state_nxt = ST_RESP;
          cnt_nxt   = '0;
        end else if ((TIMEOUT != 0) && (cnt == CNT_LAST)) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
          abort     = 1'b1;
        end else begin
          cnt_nxt = cnt + cnt_t'(1);
        end
      end
      ST_RESP: begin
        if (bus_rvalid) begin
          state_nxt = ST_IDLE;
          bus_done  = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Transaction capture at grant time. The bus fields come straight from
  // these registers so they stay frozen for the whole address phase.
  // rr_last starts at the data side so fetch wins the first tie.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_last <= OWN_D;
      owner_q <= OWN_IF;
      wr_q    <= 1'b0;
      bytes_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (gnt[0]) begin
      rr_last <= OWN_IF;
      owner_q <= OWN_IF;
      if (!misaligned) begin
        wr_q    <= 1'b0;
        bytes_q <= fetch_bytes;
        addr_q  <= if_addr;
        wdata_q <= '0;
      end
    end else if (gnt[1]) begin
      rr_last <= OWN_D;
      owner_q <= OWN_D;
      wr_q    <= d_wr;
      bytes_q <= d_bytes;
      addr_q  <= d_addr;
      wdata_q <= d_wdata;
    end
  end

  assign bus_wr    = wr_q;
  assign bus_bytes = bytes_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;

  // Registered response steering. The three sources are mutually exclusive:
  // a misaligned fetch only happens in IDLE, aborts only in ADDR and bus
  // responses only in RESP. Valid pulses last one cycle; data holds.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      if_rvalid <= 1'b0;
      if_err    <= 1'b0;
      if_rdata  <= '0;
      d_rvalid  <= 1'b0;
      d_err     <= 1'b0;
      d_rdata   <= '0;
    end else begin
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      if (fetch_fault) begin
        if_rvalid <= 1'b1;
        if_err    <= 1'b1;
        if_rdata  <= '0;
      end else if (abort) begin
        if (owner_q == OWN_IF) begin
          if_rvalid <= 1'b1;
          if_err    <= 1'b1;
          if_rdata  <= '0;
        end else begin
          d_rvalid  <= 1'b1;
          d_err     <= 1'b1;
          d_rdata   <= '0;
        end
      end else if (bus_done) begin
        if (owner_q == OWN_IF) begin
          if_rvalid <= 1'b1;
          if_err    <= bus_err;
          if_rdata  <= fetch_word;
        end else begin
          d_rvalid  <= 1'b1;
          d_err     <= bus_err;
          d_rdata   <= bus_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arb.sv
// ----------------------------------------------------------------------------
// tb_mem_arb
// Self-checking bench for mem_arb (XLEN=64, TIMEOUT=8). Single-requester
// transactions come from a vector table; arbitration, reset and multi-cycle
// corner cases are hand-written sequences. Expected responses are queued
// when the bench drives the bus response and popped by a monitor whenever
// the DUT pulses a response valid.
// ----------------------------------------------------------------------------
module tb_mem_arb;

  localparam int XLEN = 64;
  localparam int TO   = 8;

  logic              clk;
  logic              rstn;
  logic              if_req;
  logic [XLEN-1:0]   if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [31:0]       if_rdata;
  logic              if_err;
  logic              d_req;
  logic              d_wr;
  logic [XLEN/8-1:0] d_bytes;
  logic [XLEN-1:0]   d_addr;
  logic [XLEN-1:0]   d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [XLEN-1:0]   d_rdata;
  logic              d_err;
  logic              bus_req;
  logic              bus_wr;
  logic [XLEN/8-1:0] bus_bytes;
  logic [XLEN-1:0]   bus_addr;
  logic [XLEN-1:0]   bus_wdata;
  logic              bus_gnt;
  logic              bus_rvalid;
  logic [XLEN-1:0]   bus_rdata;
  logic              bus_err;

  typedef struct {
    bit          is_fetch;
    logic [63:0] addr;
    bit          wr;
    logic [7:0]  bytes;
    logic [63:0] wdata;
    int          gnt_delay;
    bit          timeout;
    logic [63:0] rdata;
    bit          err;
    logic [7:0]  exp_bytes;
    bit          exp_err;
    logic [63:0] exp_rdata;
  } vec_t;

  typedef struct {
    bit          is_fetch;
    logic        err;
    logic [63:0] rdata;
  } sb_t;

  sb_t  exp_q[$];
  sb_t  mon_e;
  sb_t  push_e;
  vec_t vecs[8];
  int   total;
  int   bad;

  mem_arb #(
    .XLEN    (XLEN),
    .TIMEOUT (TO)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_gnt     (if_gnt),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .if_err     (if_err),
    .d_req      (d_req),
    .d_wr       (d_wr),
    .d_bytes    (d_bytes),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_gnt      (d_gnt),
    .d_rvalid   (d_rvalid),
    .d_rdata    (d_rdata),
    .d_err      (d_err),
    .bus_req    (bus_req),
    .bus_wr     (bus_wr),
    .bus_bytes  (bus_bytes),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_gnt    (bus_gnt),
    .bus_rvalid (bus_rvalid),
    .bus_rdata  (bus_rdata),
    .bus_err    (bus_err)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case a sequence wedges.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pushExp(input bit is_fetch, input logic err, input logic [63:0] rdata);
    push_e.is_fetch = is_fetch;
    push_e.err      = err;
    push_e.rdata    = rdata;
    exp_q.push_back(push_e);
  endtask

  // Response monitor: every valid pulse must match the oldest expectation,
  // on the right port only, and grants must never overlap.
  always @(negedge clk) begin
    if (rstn) begin
      if (if_gnt || d_gnt) begin
        checkOutput("single gnt", {62'b0, if_gnt, d_gnt} & 64'h3, (if_gnt && d_gnt) ? 64'h0 : {62'b0, if_gnt, d_gnt});
      end
      if (if_rvalid || d_rvalid) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected rvalid", {62'b0, if_rvalid, d_rvalid}, 64'h0);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("rvalid port", {62'b0, if_rvalid, d_rvalid}, mon_e.is_fetch ? 64'h2 : 64'h1);
          if (mon_e.is_fetch) begin
            checkOutput("if_err", {63'b0, if_err}, {63'b0, mon_e.err});
            checkOutput("if_rdata", {32'b0, if_rdata}, mon_e.rdata);
          end else begin
            checkOutput("d_err", {63'b0, d_err}, {63'b0, mon_e.err});
            checkOutput("d_rdata", d_rdata, mon_e.rdata);
          end
        end
      end
    end
  end

  // One single-requester transaction, driven from idle at posedge+1.
  task automatic applyStimulus(input vec_t v, input int idx);
    bit misal;
    misal = v.is_fetch && (v.addr[1:0] != 2'b00);
    if (v.is_fetch) begin
      if_req  = 1'b1;
      if_addr = v.addr;
    end else begin
      d_req   = 1'b1;
      d_wr    = v.wr;
      d_bytes = v.bytes;
      d_addr  = v.addr;
      d_wdata = v.wdata;
    end
    #1;
    checkOutput($sformatf("vec%0d gnt", idx), {63'b0, v.is_fetch ? if_gnt : d_gnt}, 64'h1);
    checkOutput($sformatf("vec%0d other gnt", idx), {63'b0, v.is_fetch ? d_gnt : if_gnt}, 64'h0);
    if (misal) begin
      checkOutput($sformatf("vec%0d misaligned bus_req", idx), {63'b0, bus_req}, 64'h0);
      pushExp(v.is_fetch, v.exp_err, v.exp_rdata);
      @(posedge clk); #1;
      if_req = 1'b0;
      checkOutput($sformatf("vec%0d if_rvalid", idx), {63'b0, if_rvalid}, 64'h1);
      checkOutput($sformatf("vec%0d no bus_req", idx), {63'b0, bus_req}, 64'h0);
      return;
    end
    @(posedge clk); #1;
    if_req = 1'b0;
    d_req  = 1'b0;
    for (int c = 0; c < 32; c++) begin
      checkOutput($sformatf("vec%0d c%0d bus_req", idx, c), {63'b0, bus_req}, 64'h1);
      checkOutput($sformatf("vec%0d c%0d bus_addr", idx, c), bus_addr, v.addr);
      checkOutput($sformatf("vec%0d c%0d bus_wr", idx, c), {63'b0, bus_wr}, {63'b0, v.wr});
      checkOutput($sformatf("vec%0d c%0d bus_bytes", idx, c), {56'b0, bus_bytes}, {56'b0, v.exp_bytes});
      if (!v.is_fetch) begin
        checkOutput($sformatf("vec%0d c%0d bus_wdata", idx, c), bus_wdata, v.wdata);
      end
      if (v.timeout) begin
        if (c == TO - 1) begin
          pushExp(v.is_fetch, v.exp_err, v.exp_rdata);
          @(posedge clk); #1;
          checkOutput($sformatf("vec%0d timeout bus_req", idx), {63'b0, bus_req}, 64'h0);
          checkOutput($sformatf("vec%0d timeout rvalid", idx), {63'b0, v.is_fetch ? if_rvalid : d_rvalid}, 64'h1);
          return;
        end
      end else if (c == v.gnt_delay) begin
        bus_gnt = 1'b1;
        @(posedge clk); #1;
        bus_gnt = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    checkOutput($sformatf("vec%0d resp bus_req", idx), {63'b0, bus_req}, 64'h0);
    pushExp(v.is_fetch, v.exp_err, v.exp_rdata);
    bus_rvalid = 1'b1;
    bus_rdata  = v.rdata;
    bus_err    = v.err;
    @(posedge clk); #1;
    bus_rvalid = 1'b0;
    bus_err    = 1'b0;
    checkOutput($sformatf("vec%0d rvalid", idx), {63'b0, v.is_fetch ? if_rvalid : d_rvalid}, 64'h1);
  endtask

  initial begin
    bit exp_if;
    total      = 0;
    bad        = 0;
    rstn       = 1'b0;
    if_req     = 1'b0;
    if_addr    = '0;
    d_req      = 1'b0;
    d_wr       = 1'b0;
    d_bytes    = '0;
    d_addr     = '0;
    d_wdata    = '0;
    bus_gnt    = 1'b0;
    bus_rvalid = 1'b0;
    bus_rdata  = '0;
    bus_err    = 1'b0;

    //                fetch addr                 wr    bytes  wdata     dly to    bus_rdata                 err   exp_bytes e_err exp_rdata
    vecs[0] = '{1'b1, 64'h0000_0000_0000_0100, 1'b0, 8'h00, 64'h0,    0, 1'b0, 64'hDEAD_BEEF_0123_4567, 1'b0, 8'h0F, 1'b0, 64'h0000_0000_0123_4567};
    vecs[1] = '{1'b1, 64'h0000_0000_0000_010C, 1'b0, 8'h00, 64'h0,    2, 1'b0, 64'hA5A5_A5A5_5A5A_5A5A, 1'b0, 8'hF0, 1'b0, 64'h0000_0000_A5A5_A5A5};
    vecs[2] = '{1'b0, 64'h0000_0000_0000_2000, 1'b1, 8'h03, 64'hABCD, 5, 1'b0, 64'h0,                    1'b0, 8'h03, 1'b0, 64'h0};
    vecs[3] = '{1'b0, 64'h0000_0000_0000_3008, 1'b0, 8'hFF, 64'h0,    1, 1'b0, 64'h0123_4567_89AB_CDEF, 1'b1, 8'hFF, 1'b1, 64'h0123_4567_89AB_CDEF};
    vecs[4] = '{1'b0, 64'h0000_0000_0000_4000, 1'b0, 8'h0F, 64'h0,    0, 1'b1, 64'h0,                    1'b0, 8'h0F, 1'b1, 64'h0};
    vecs[5] = '{1'b1, 64'h0000_0000_8000_0002, 1'b0, 8'h00, 64'h0,    0, 1'b0, 64'h0,                    1'b0, 8'h00, 1'b1, 64'h0};
    vecs[6] = '{1'b0, 64'h0000_0000_0000_5000, 1'b0, 8'hF0, 64'h0,    0, 1'b0, 64'h0000_0055_0000_0000, 1'b0, 8'hF0, 1'b0, 64'h0000_0055_0000_0000};
    vecs[7] = '{1'b1, 64'h0000_0000_8000_0006, 1'b0, 8'h00, 64'h0,    0, 1'b0, 64'h0,                    1'b0, 8'h00, 1'b1, 64'h0};

    // Reset state: everything low.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst if_gnt", {63'b0, if_gnt}, 64'h0);
    checkOutput("rst d_gnt", {63'b0, d_gnt}, 64'h0);
    checkOutput("rst if_rvalid", {63'b0, if_rvalid}, 64'h0);
    checkOutput("rst d_rvalid", {63'b0, d_rvalid}, 64'h0);
    checkOutput("rst if_rdata", {32'b0, if_rdata}, 64'h0);
    checkOutput("rst d_rdata", d_rdata, 64'h0);
    checkOutput("rst errs", {62'b0, if_err, d_err}, 64'h0);
    checkOutput("rst bus_req", {63'b0, bus_req}, 64'h0);
    checkOutput("rst bus_wr", {63'b0, bus_wr}, 64'h0);
    checkOutput("rst bus_bytes", {56'b0, bus_bytes}, 64'h0);
    checkOutput("rst bus_addr", bus_addr, 64'h0);
    checkOutput("rst bus_wdata", bus_wdata, 64'h0);
    rstn = 1'b1;

    // Both requesters in the first cycle after reset: fetch wins the tie.
    if_req  = 1'b1;
    if_addr = 64'h0000_0000_8000_0004;
    d_req   = 1'b1;
    d_wr    = 1'b0;
    d_bytes = 8'hFF;
    d_addr  = 64'h0000_0000_0000_1000;
    #1;
    checkOutput("first tie if_gnt", {63'b0, if_gnt}, 64'h1);
    checkOutput("first tie d_gnt", {63'b0, d_gnt}, 64'h0);
    @(posedge clk); #1;
    if_req = 1'b0;
    #1;
    checkOutput("first d_gnt in ADDR", {63'b0, d_gnt}, 64'h0);
    checkOutput("first bus_bytes", {56'b0, bus_bytes}, 64'hF0);
    checkOutput("first bus_addr", bus_addr, 64'h0000_0000_8000_0004);
    bus_gnt = 1'b1;
    @(posedge clk); #1;
    bus_gnt = 1'b0;
    pushExp(1'b1, 1'b0, 64'h0000_0000_1122_3344);
    bus_rvalid = 1'b1;
    bus_rdata  = 64'h1122_3344_5566_7788;
    @(posedge clk); #1;
    bus_rvalid = 1'b0;
    #1;
    checkOutput("second d_gnt", {63'b0, d_gnt}, 64'h1);
    checkOutput("first if_rvalid", {63'b0, if_rvalid}, 64'h1);
    @(posedge clk); #1;
    d_req = 1'b0;
    checkOutput("second bus_addr", bus_addr, 64'h0000_0000_0000_1000);
    checkOutput("second bus_bytes", {56'b0, bus_bytes}, 64'hFF);
    bus_gnt = 1'b1;
    @(posedge clk); #1;
    bus_gnt = 1'b0;
    pushExp(1'b0, 1'b0, 64'h1122_3344_5566_7788);
    bus_rvalid = 1'b1;
    @(posedge clk); #1;
    bus_rvalid = 1'b0;
    checkOutput("second d_rvalid", {63'b0, d_rvalid}, 64'h1);

    // Both held for six transactions: grants alternate starting with fetch.
    if_req  = 1'b1;
    if_addr = 64'h0000_0000_8000_0000;
    d_req   = 1'b1;
    d_addr  = 64'h0000_0000_0000_2000;
    for (int k = 0; k < 6; k++) begin
      #1;
      exp_if = (k % 2) == 0;
      checkOutput($sformatf("alt%0d if_gnt", k), {63'b0, if_gnt}, {63'b0, exp_if});
      checkOutput($sformatf("alt%0d d_gnt", k), {63'b0, d_gnt}, {63'b0, !exp_if});
      @(posedge clk); #1;
      checkOutput($sformatf("alt%0d bus_addr", k), bus_addr,
                  exp_if ? 64'h0000_0000_8000_0000 : 64'h0000_0000_0000_2000);
      bus_gnt = 1'b1;
      @(posedge clk); #1;
      bus_gnt = 1'b0;
      bus_rdata = {32'(k + 1), 32'(k + 100)};
      pushExp(exp_if, 1'b0, exp_if ? {32'b0, 32'(k + 100)} : {32'(k + 1), 32'(k + 100)});
      bus_rvalid = 1'b1;
      @(posedge clk); #1;
      bus_rvalid = 1'b0;
    end
    if_req = 1'b0;
    d_req  = 1'b0;
    @(posedge clk); #1;

    // Single-requester vectors, back to back.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i], i);
    end
    @(posedge clk); #1;

    // Reset asserted during RESP: transaction dropped, later stray response ignored.
    d_req   = 1'b1;
    d_wr    = 1'b0;
    d_bytes = 8'hFF;
    d_addr  = 64'h0000_0000_0000_6000;
    #1;
    checkOutput("rstresp d_gnt", {63'b0, d_gnt}, 64'h1);
    @(posedge clk); #1;
    d_req   = 1'b0;
    bus_gnt = 1'b1;
    @(posedge clk); #1;
    bus_gnt = 1'b0;
    rstn    = 1'b0;
    #1;
    checkOutput("rstresp bus_req", {63'b0, bus_req}, 64'h0);
    checkOutput("rstresp bus_addr", bus_addr, 64'h0);
    checkOutput("rstresp bus_bytes", {56'b0, bus_bytes}, 64'h0);
    checkOutput("rstresp d_rdata", d_rdata, 64'h0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    bus_rvalid = 1'b1;
    bus_rdata  = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge clk); #1;
    bus_rvalid = 1'b0;
    checkOutput("stray d_rvalid", {63'b0, d_rvalid}, 64'h0);
    checkOutput("stray if_rvalid", {63'b0, if_rvalid}, 64'h0);
    checkOutput("stray bus_req", {63'b0, bus_req}, 64'h0);
    @(posedge clk); #1;
    checkOutput("stray d_rvalid late", {63'b0, d_rvalid}, 64'h0);

    repeat (2) @(posedge clk);
    #1;
    checkOutput("scoreboard drained", 64'(exp_q.size()), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
